// File: rtl/frac_logic_pkg.sv
// Shared definitions for the fracturable K-input logic element:
// configuration layout helpers and the decoded configuration bundle.
package frac_logic_pkg;

    localparam int K_MAX  = 8;
    localparam int TT_MAX = 1 << K_MAX;

    function automatic int cfg_bits(input int k);
        return (1 << k) + 3;
    endfunction

    function automatic int tt_lsb();
        return 0;
    endfunction

    function automatic int frac_mode_idx(input int k);
        return 1 << k;
    endfunction

    function automatic int reg_en_idx(input int k, input int i);
        return (1 << k) + 1 + i;
    endfunction

    // Truth table is zero-extended to the largest legal K.
    typedef struct packed {
        logic [TT_MAX-1:0] tt;
        logic              frac_mode;
        logic [1:0]        reg_en;
    } cfg_t;

endpackage

// File: rtl/frac_logic_ccff_chain.sv
// Double-buffered configuration chain: shadow shift register, saturating
// bit counter, commit validation and the active configuration store.
module frac_logic_ccff_chain
    import frac_logic_pkg::*;
#(
    parameter int K        = 6,
    parameter int CFG_BITS = cfg_bits(K),
    parameter int CNT_W    = $clog2(CFG_BITS + 1)
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                ccff_head,
    input  logic                ccff_shift_en,
    input  logic                ccff_commit,
    output logic [CFG_BITS-1:0] act,
    output logic                cfg_valid,
    output logic                cfg_err,
    output logic [CNT_W-1:0]    cfg_count,
    output logic                ccff_tail
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] sr_q, sr_d;
    logic [CFG_BITS-1:0] act_q, act_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                commit_ok;

    assign commit_ok = ccff_commit && !ccff_shift_en && (cnt_q == CNT_FULL);

    always_comb begin
        sr_d    = sr_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        if (ccff_shift_en) begin
            sr_d = {sr_q[CFG_BITS-2:0], ccff_head};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Any commit attempt restarts the count, accepted or not.
        if (ccff_commit) begin
            cnt_d = '0;
            err_d = !commit_ok;
        end
        if (commit_ok) begin
            act_d   = sr_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sr_q    <= '0;
            act_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign act       = act_q;
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;
    assign cfg_count = cnt_q;
    assign ccff_tail = sr_q[CFG_BITS-1];

endmodule

// File: rtl/frac_logic_ccff_k.sv
// Fracturable K-input LUT with double-buffered configuration chain and
// optional per-output registering.
module frac_logic_ccff_k
    import frac_logic_pkg::*;
#(
    parameter int K        = 6,
    parameter int CFG_BITS = cfg_bits(K),
    parameter int CNT_W    = $clog2(CFG_BITS + 1)
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic [K-1:0]     frac_logic_in,
    input  logic             ccff_head,
    input  logic             ccff_shift_en,
    input  logic             ccff_commit,
    output logic [1:0]       frac_logic_out,
    output logic             ccff_tail,
    output logic             cfg_valid,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cfg_count
);

    localparam int TT_W = 1 << K;

    logic [CFG_BITS-1:0] act;
    cfg_t                cfg;
    logic [K_MAX-1:0]    lut_idx;
    logic [K_MAX-1:0]    lo_idx;
    logic [K_MAX-1:0]    hi_idx;
    logic                lutk;
    logic                lo;
    logic                hi;
    logic [1:0]          comb;
    logic [1:0]          q_q, q_d;

    frac_logic_ccff_chain #(
        .K        (K),
        .CFG_BITS (CFG_BITS),
        .CNT_W    (CNT_W)
    ) u_chain (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_commit   (ccff_commit),
        .act           (act),
        .cfg_valid     (cfg_valid),
        .cfg_err       (cfg_err),
        .cfg_count     (cfg_count),
        .ccff_tail     (ccff_tail)
    );

    always_comb begin
        cfg           = '0;
        cfg.tt        = TT_MAX'(act[tt_lsb() +: TT_W]);
        cfg.frac_mode = act[frac_mode_idx(K)];
        cfg.reg_en[0] = act[reg_en_idx(K, 0)];
        cfg.reg_en[1] = act[reg_en_idx(K, 1)];
    end

    // Fractured halves share the low K-1 inputs; the MSB selects the half.
    always_comb begin
        lut_idx = K_MAX'(frac_logic_in);
        lo_idx  = K_MAX'(frac_logic_in[K-2:0]);
        hi_idx  = lo_idx | K_MAX'(TT_W / 2);
        lutk    = cfg.tt[lut_idx];
        lo      = cfg.tt[lo_idx];
        hi      = cfg.tt[hi_idx];
        comb[0] = cfg.frac_mode ? lo : lutk;
        comb[1] = hi;
        q_d     = comb;
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            frac_logic_out[i] = cfg.reg_en[i] ? q_q[i] : comb[i];
        end
    end

endmodule

// File: tb/tb_frac_logic_ccff_k.sv
// Directed bench for frac_logic_ccff_k (K=6) with a bit-history model
// checked every cycle plus literal expectations.
module tb_frac_logic_ccff_k;

    localparam int NB = 67;

    logic       clk;
    logic       rst_n;
    logic [5:0] fin;
    logic       head;
    logic       shift;
    logic       commit;
    logic [1:0] out;
    logic       tail;
    logic       valid;
    logic       err;
    logic [6:0] count;

    int tests;
    int fails;
    bit chk_en;

    frac_logic_ccff_k dut (
        .prog_clk       (clk),
        .pReset         (rst_n),
        .frac_logic_in  (fin),
        .ccff_head      (head),
        .ccff_shift_en  (shift),
        .ccff_commit    (commit),
        .frac_logic_out (out),
        .ccff_tail      (tail),
        .cfg_valid      (valid),
        .cfg_err        (err),
        .cfg_count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Model: history of shifted bits, newest last; active config as bits.
    bit       hist[$];
    int       mcnt;
    bit [66:0] mact;
    bit       mvalid;
    bit       merr;
    bit [1:0] mq;

    function automatic bit sr_bit(input int j);
        if (j < hist.size()) return hist[hist.size() - 1 - j];
        return 1'b0;
    endfunction

    function automatic bit [1:0] comb_of(input bit [66:0] a, input int x);
        int lo_i;
        bit lutk, lo, hi;
        lo_i = x % 32;
        lutk = a[x];
        lo   = a[lo_i];
        hi   = a[lo_i + 32];
        return {hi, (a[64] ? lo : lutk)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            mcnt   = 0;
            mact   = '0;
            mvalid = 0;
            merr   = 0;
            mq     = '0;
        end else begin
            mq   = comb_of(mact, int'(fin));
            merr = 0;
            if (commit) begin
                if (!shift && mcnt == NB) begin
                    for (int j = 0; j < NB; j++) mact[j] = sr_bit(j);
                    mvalid = 1;
                end else begin
                    merr = 1;
                end
            end
            if (shift) begin
                hist.push_back(head);
                if (hist.size() > NB) void'(hist.pop_front());
                if (mcnt < NB) mcnt++;
            end
            if (commit) mcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit [1:0] c, e;
            c = comb_of(mact, int'(fin));
            for (int i = 0; i < 2; i++) e[i] = mact[65 + i] ? mq[i] : c[i];
            chk("model_out", 32'(out), 32'(e));
            chk("model_tail", 32'(tail), 32'(sr_bit(NB - 1)));
            chk("model_valid", 32'(valid), 32'(mvalid));
            chk("model_err", 32'(err), 32'(merr));
            chk("model_count", 32'(count), 32'(mcnt));
        end
    end

    task automatic drv(input bit s, input bit h, input bit c,
                       input logic [5:0] x);
        @(posedge clk);
        #1;
        shift  = s;
        head   = h;
        commit = c;
        fin    = x;
    endtask

    function automatic bit [66:0] mkcfg(input bit [63:0] tt, input bit fm,
                                        input bit [1:0] re);
        return {re, fm, tt};
    endfunction

    function automatic bit [63:0] xor_or_tt();
        bit [63:0] t;
        for (int j = 0; j < 32; j++) begin
            t[j]      = ^(5'(j));
            t[32 + j] = (j != 0);
        end
        return t;
    endfunction

    // Shifts v MSB first, optionally preceded by junk bits, then commits.
    task automatic load(input bit [66:0] v, input int extra,
                        input bit toggle);
        logic [5:0] x;
        x = fin;
        for (int j = 0; j < extra; j++) drv(1, 1'($urandom), 0, x);
        for (int j = NB - 1; j >= 0; j--) begin
            if (toggle) x = 6'($urandom);
            drv(1, v[j], 0, x);
        end
        drv(0, 0, 1, x);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        chk_en = 0;
        rst_n  = 0;
        shift  = 0;
        head   = 0;
        commit = 0;
        fin    = 0;

        // Reset with random inputs.
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            fin    = 6'($urandom);
            head   = 1'($urandom);
            shift  = 1'($urandom);
            commit = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_out", 32'(out), 0);
        chk("rst_tail", 32'(tail), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(valid), 0);
        @(posedge clk);
        #1;
        shift  = 0;
        commit = 0;
        rst_n  = 1;
        chk_en = 1;

        // Full AND6 load.
        load(mkcfg(64'h8000_0000_0000_0000, 0, 2'b00), 0, 0);
        drv(0, 0, 0, 6'h3F);
        @(negedge clk);
        chk("and6_valid", 32'(valid), 1);
        chk("and6_count", 32'(count), 0);
        chk("and6_3f", 32'(out[0]), 1);
        drv(0, 0, 0, 6'h3E);
        @(negedge clk);
        chk("and6_3e", 32'(out[0]), 0);

        // Fractured XOR5 / OR5.
        load(mkcfg(xor_or_tt(), 1, 2'b00), 0, 0);
        drv(0, 0, 0, 6'h01);
        @(negedge clk);
        chk("frac_01", 32'(out), 2'b11);
        drv(0, 0, 0, 6'h00);
        @(negedge clk);
        chk("frac_00", 32'(out), 2'b00);
        drv(0, 0, 0, 6'h03);
        @(negedge clk);
        chk("frac_03", 32'(out), 2'b10);

        // Short-shift commit is rejected; old config stays active.
        for (int j = 0; j < NB - 1; j++) drv(1, 1'($urandom), 0, 6'h03);
        drv(0, 0, 1, 6'h03);
        drv(0, 0, 0, 6'h01);
        @(negedge clk);
        chk("short_err", 32'(err), 1);
        chk("short_count", 32'(count), 0);
        chk("short_keep", 32'(out), 2'b11);
        drv(0, 0, 0, 6'h01);
        @(negedge clk);
        chk("short_err_pulse", 32'(err), 0);
        drv(1, 1, 1, 6'h01);
        drv(0, 0, 0, 6'h01);
        @(negedge clk);
        chk("shcm_err", 32'(err), 1);
        chk("shcm_count", 32'(count), 0);
        chk("shcm_tail", 32'(tail), 32'(sr_bit(NB - 1)));

        // Registered outputs, with over-shifting before the load.
        load(mkcfg(xor_or_tt(), 1, 2'b11), 3, 0);
        drv(0, 0, 0, 6'h01);
        drv(0, 0, 0, 6'h00);
        @(negedge clk);
        chk("reg_lag", 32'(out), 2'b11);
        drv(0, 0, 0, 6'h00);
        @(negedge clk);
        chk("reg_follow", 32'(out), 2'b00);
        for (int j = 0; j < 12; j++) drv(0, 0, 0, 6'($urandom));

        // Reload combinational while inputs toggle.
        load(mkcfg(64'h8000_0000_0000_0000, 0, 2'b00), 0, 1);
        drv(0, 0, 0, 6'h3F);
        @(negedge clk);
        chk("reload_and6", 32'(out), 2'b11);
        for (int j = 0; j < 8; j++) drv(0, 0, 0, 6'($urandom));

        // Reset mid-shift.
        for (int j = 0; j < 30; j++) drv(1, 1'($urandom), 0, 6'($urandom));
        #3;
        rst_n = 0;
        #1;
        chk("mid_out", 32'(out), 0);
        chk("mid_tail", 32'(tail), 0);
        chk("mid_count", 32'(count), 0);
        chk("mid_valid", 32'(valid), 0);
        drv(0, 0, 0, 6'h3F);
        rst_n = 1;

        // First shifted bit reaches the tail after exactly 67 shifts.
        drv(1, 1, 0, 6'h3F);
        for (int j = 0; j < NB - 2; j++) drv(1, 0, 0, 6'h3F);
        drv(0, 0, 0, 6'h3F);
        @(negedge clk);
        chk("tail_66", 32'(tail), 0);
        drv(1, 0, 0, 6'h3F);
        drv(0, 0, 0, 6'h3F);
        @(negedge clk);
        chk("tail_67", 32'(tail), 1);
        drv(0, 0, 1, 6'h3F);
        drv(0, 0, 0, 6'h3F);
        @(negedge clk);
        chk("reload_valid", 32'(valid), 1);
        drv(0, 0, 0, 6'h00);
        drv(0, 0, 0, 6'h00);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frac_logic_ccff_k.md
# frac_logic_ccff_k

Parametrised fracturable K-input logic element with a double-buffered configuration chain. It is the successor to the fixed 6-input fracturable LUT tile, generalised in LUT size and extended with a shadow/active configuration split, a bit counter, commit validation and per-output registered mode. It sits inside the fle of a CLB and is chained head-to-tail with neighbouring elements on the configuration path.

## Interface
- K, default 6: LUT inputs; fractures into two (K-1)-input LUTs; legal 3..8.
- CFG_BITS, derived as 2^K + 3: truth table plus frac_mode plus reg_en[1:0]; 67 for K=6.
- CNT_W, derived as clog2(CFG_BITS+1): width of the bit counter.
- prog_clk  in  1  sole clock, used for both configuration and the output registers.
- pReset  in  1  asynchronous, active-low reset.
- frac_logic_in  in  K  LUT inputs; frac_logic_in[0] is the LSB of the truth-table index.
- ccff_head  in  1  serial configuration data in.
- ccff_shift_en  in  1  shift one bit this cycle.
- ccff_commit  in  1  request copy of shadow chain into active config.
- frac_logic_out  out  2  logic outputs.
- ccff_tail  out  1  serial configuration data out, registered.
- cfg_valid  out  1  active config has been loaded at least once.
- cfg_err  out  1  one-cycle pulse when a commit is rejected.
- cfg_count  out  CNT_W  bits shifted since the last commit attempt, saturating.

## Operation
- **Shadow chain sr[CFG_BITS-1:0].** When shift_en=1: sr <= {sr[CFG_BITS-2:0], ccff_head}.
  - ccff_tail = sr[CFG_BITS-1].
  - The first bit shifted in lands at the MSB after CFG_BITS shifts.
- **Counter.** cfg_count increments on each shift and saturates at CFG_BITS. Over-shifting is legal; the last CFG_BITS bits win.
- **Commit, accepted.** Condition: ccff_commit=1, shift_en=0, cfg_count==CFG_BITS. Result: act <= sr, cfg_valid <= 1, cfg_count <= 0.
- **Commit, rejected.** Condition: commit with cfg_count != CFG_BITS, or commit coinciding with shift_en. Result: act unchanged, cfg_err pulses 1 cycle, cfg_count <= 0.
  - When coinciding with shift_en, the shift still happens, and the count is then 0 regardless of the shift.
- **Active layout.**
  - act[2^K-1:0] is the truth table tt.
  - act[2^K] is frac_mode.
  - act[2^K+1+i] is reg_en[i].
- **LUT evaluation.**
  - lutk = tt[in].
  - lo = tt[{0, in[K-2:0]}].
  - hi = tt[{1, in[K-2:0]}].
  - comb0 = frac_mode ? lo : lutk.
  - comb1 = hi.
- **Output registers.** q[i] <= comb[i] every cycle. frac_logic_out[i] = reg_en[i] ? q[i] : comb[i].
- **Shadow isolation.** Shifting never disturbs act; the fabric keeps running on the old config during reprogramming.

## Timing
- **Reset values.** Asserting pReset=0 clears, asynchronously:
  - sr, act and q to 0;
  - cfg_count to 0;
  - cfg_valid and cfg_err to 0.
- **Outputs in reset.** frac_logic_out=0 and ccff_tail=0.
- **Deassertion.** Synchronous to prog_clk by the parent.
- **Chain latency.** A bit appears on ccff_tail after CFG_BITS shift_en cycles; shift_en low freezes the chain.
- **Commit latency.** act updates at the commit edge, so combinational outputs reflect the new config in the following cycle. Registered outputs reflect it one cycle later still.
- **cfg_err.** Asserted exactly the cycle after the rejected commit edge.
- **Reset mid-shift or mid-commit.** Everything returns to reset values; cfg_valid=0 until a full reload and commit.
- **Output path.** frac_logic_in to frac_logic_out is combinational when reg_en=0. It is 1-cycle registered when reg_en=1.

## Structure
- **Package frac_logic_pkg.**
  - Functions cfg_bits(K), tt_lsb, frac_mode_idx(K) and reg_en_idx(K, i).
  - Typedef for the decoded config struct {tt, frac_mode, reg_en}.
- **Sub-module frac_logic_ccff_chain.** Holds the shift register, the saturating counter, commit validation and cfg_err.
  - Outputs: act, cfg_valid, ccff_tail.
- **Top.** Holds the LUT decode, the fracture mux and the output registers.

## Test plan
- **Reset.** Apply reset with random inputs → out=00, tail=0, count=0, valid=0.
- **Full LUT load (K=6).** Shift 67 bits encoding tt=AND6, frac_mode=0, reg_en=00, then commit → valid=1, count=0. in=3F gives out0=1; in=3E gives out0=0.
- **Fractured mode.** Load tt lower half=XOR5 and upper half=OR5, frac_mode=1.
  - in=00001 → out=11.
  - in=00000 → out=00.
  - in=00011 → out0=0, out1=1.
- **Short-shift commit.** Commit after 66 shifts → cfg_err pulse, act unchanged, count=0. Commit with shift_en=1 → shift occurs, commit rejected.
- **Registered outputs.** Load with reg_en=11, then step inputs → out follows comb with exactly 1-cycle lag. Reload with reg_en=00 while inputs toggle → old function persists during shifting and switches in the cycle after commit.
- **Reset mid-shift.** Assert pReset after 30 shifts → all state cleared. Then a full 67-bit load and commit succeeds. Also check ccff_tail shows the first shifted bit after exactly 67 shifts.
